// File: rtl/sample_checker.sv
// Receive-side checker for the camera test-pattern stream: tracks line/word
// position after each frame sync and compares every word with the expected pattern.
module sample_checker #(
  parameter int WORDS_PER_LINE  = 2048,
  parameter int LINES_PER_FRAME = 990
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic        framesync_i,
  input  logic [15:0] data_i,
  input  logic        data_valid_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic        overrun_o,
  output logic [15:0] error_count_o,
  output logic [9:0]  line_count_o,
  output logic [11:0] word_count_o,
  output logic [9:0]  first_err_line_o,
  output logic [11:0] first_err_word_o,
  output logic [15:0] first_err_data_o
);

  localparam int DATA_W = 16;
  localparam logic [11:0] LAST_W = 12'(WORDS_PER_LINE - 1);
  localparam logic [9:0]  LAST_L = 10'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_t;

  function automatic logic [DATA_W-1:0] expected_word(input logic [7:0] l,
                                                      input logic [7:0] w);
    return {l, w} ^ {DATA_W{l[0]}};
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] c);
    return (c == {DATA_W{1'b1}}) ? c : c + 16'd1;
  endfunction

  state_t state_q, state_d;

  logic              fs_q;
  logic              sof_pend_q, sof_pend_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] err_cnt_q, err_cnt_nx;

  logic              run, sof, sof_eff, early, start, accept, mismatch, frame_end;
  logic [9:0]        cur_l;
  logic [11:0]       cur_w;
  logic [DATA_W-1:0] err_base, err_cnt_d;

  logic              frame_done_d, frame_ok_d, overrun_d;
  logic [DATA_W-1:0] error_count_d, fed_d;
  logic [9:0]        line_d, fel_d;
  logic [11:0]       word_d, few_d;

  assign run      = enable_i & ~clear_i;
  assign sof      = framesync_i & ~fs_q;
  assign sof_eff  = sof | sof_pend_q;
  assign early    = run & (state_q == ACTIVE) & sof;
  assign start    = early | (run & (state_q == WAIT_SOF) & sof_eff);
  assign accept   = data_valid_i & ((run & (state_q == ACTIVE)) | start);
  // A frame start restarts position so the sync-cycle word is word 0 of line 0.
  assign cur_l    = start ? '0 : line_count_o;
  assign cur_w    = start ? '0 : word_count_o;
  assign mismatch = accept & (data_i != expected_word(cur_l[7:0], cur_w[7:0]));
  assign frame_end = accept & (cur_l == LAST_L) & (cur_w == LAST_W);
  assign err_base = start ? '0 : err_cnt_q;
  assign err_cnt_d = mismatch ? sat_inc(err_base) : err_base;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = enable_i ? WAIT_SOF : IDLE;
    end else if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = WAIT_SOF;
        WAIT_SOF: if (sof_eff) state_d = ACTIVE;
        ACTIVE:   if (frame_end) state_d = DONE;
        DONE:     state_d = WAIT_SOF;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    line_d        = line_count_o;
    word_d        = word_count_o;
    err_cnt_nx    = err_cnt_q;
    error_count_d = error_count_o;
    armed_d       = armed_q;
    fel_d         = first_err_line_o;
    few_d         = first_err_word_o;
    fed_d         = first_err_data_o;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_o;
    overrun_d     = overrun_o;
    sof_pend_d    = 1'b0;
    if (clear_i) begin
      line_d        = '0;
      word_d        = '0;
      err_cnt_nx    = '0;
      error_count_d = '0;
      armed_d       = 1'b1;
      fel_d         = '0;
      few_d         = '0;
      fed_d         = '0;
      frame_ok_d    = 1'b0;
      overrun_d     = 1'b0;
    end else begin
      if (data_valid_i && (state_q != ACTIVE) && !accept) overrun_d = 1'b1;
      // A sync seen during DONE is replayed in WAIT_SOF on the next cycle.
      if (enable_i && (state_q == DONE)) sof_pend_d = sof;
      if (start || (run && (state_q == ACTIVE))) begin
        err_cnt_nx    = err_cnt_d;
        // The short frame's count is shown for the done pulse, then the new frame's.
        error_count_d = early ? sat_inc(err_cnt_q) : err_cnt_d;
        if (accept) begin
          if (cur_w == LAST_W) begin
            word_d = '0;
            line_d = (cur_l == LAST_L) ? '0 : cur_l + 10'd1;
          end else begin
            word_d = cur_w + 12'd1;
            line_d = cur_l;
          end
        end else if (start) begin
          word_d = '0;
          line_d = '0;
        end
        if (early) begin
          frame_done_d = 1'b1;
          frame_ok_d   = 1'b0;
          if (armed_q) begin
            fel_d   = line_count_o;
            few_d   = word_count_o;
            fed_d   = data_i;
            armed_d = 1'b1;
          end else if (mismatch) begin
            fel_d   = '0;
            few_d   = '0;
            fed_d   = data_i;
            armed_d = 1'b0;
          end else begin
            armed_d = 1'b1;
          end
        end else begin
          if (mismatch && (start || armed_q)) begin
            fel_d   = cur_l;
            few_d   = cur_w;
            fed_d   = data_i;
            armed_d = 1'b0;
          end else begin
            armed_d = start | armed_q;
          end
          if (frame_end) begin
            frame_done_d = 1'b1;
            frame_ok_d   = (err_cnt_d == '0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fs_q             <= 1'b1;
      sof_pend_q       <= 1'b0;
      armed_q          <= 1'b1;
      err_cnt_q        <= '0;
      busy_o           <= 1'b0;
      frame_done_o     <= 1'b0;
      frame_ok_o       <= 1'b0;
      overrun_o        <= 1'b0;
      error_count_o    <= '0;
      line_count_o     <= '0;
      word_count_o     <= '0;
      first_err_line_o <= '0;
      first_err_word_o <= '0;
      first_err_data_o <= '0;
    end else begin
      fs_q             <= framesync_i;
      sof_pend_q       <= sof_pend_d;
      armed_q          <= armed_d;
      err_cnt_q        <= err_cnt_nx;
      busy_o           <= (state_d == ACTIVE);
      frame_done_o     <= frame_done_d;
      frame_ok_o       <= frame_ok_d;
      overrun_o        <= overrun_d;
      error_count_o    <= error_count_d;
      line_count_o     <= line_d;
      word_count_o     <= word_d;
      first_err_line_o <= fel_d;
      first_err_word_o <= few_d;
      first_err_data_o <= fed_d;
    end
  end

endmodule

// File: doc/sample_checker.md
# sample_checker

- Receive-side checker for the camera test-pattern stream.
- Consumes 16-bit sample words qualified by a valid strobe and framed by a frame-sync pulse, tracks line and word position, and compares every word against the deterministic test pattern.
- Reports per-frame pass/fail, a saturating error count and the location of the first mismatch.
- Sits at the far end of the sample path, after the FIFO/bridge, as the bring-up and loopback counterpart of the pattern generator.

## Interface
Parameters:
- WORDS_PER_LINE, 2048: valid words per line (2..4096).
- LINES_PER_FRAME, 990: lines per frame (1..1024).

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  checker enable; low forces IDLE.
- clear_i  in  1  synchronous clear of sticky status and counters.
- framesync_i  in  1  frame sync, synchronous to clk_i; a rising edge marks start of frame (SOF).
- data_i  in  16  sample word.
- data_valid_i  in  1  data_i qualifier, one word per high cycle.
- busy_o  out  1  high in ACTIVE.
- frame_done_o  out  1  one-cycle pulse at end of every checked frame.
- frame_ok_o  out  1  result of the last completed frame; 1 = no errors.
- overrun_o  out  1  sticky; a valid word arrived outside ACTIVE.
- error_count_o  out  16  mismatches in the current or last frame; saturates at 16'hFFFF.
- line_count_o  out  10  current line index.
- word_count_o  out  12  current word index within the line.
- first_err_line_o  out  10  line of the first mismatch in the frame.
- first_err_word_o  out  12  word of the first mismatch in the frame.
- first_err_data_o  out  16  received data of the first mismatch in the frame.

## Operation
- Expected word at line L, word W: E = {L[7:0], W[7:0]} XOR (L[0] ? 16'hFFFF : 16'h0000).
- SOF detect: fs_q holds framesync_i from the previous cycle; sof = framesync_i & ~fs_q, decoded in the same cycle.
- States:
  - IDLE: entered on reset or enable_i low. Goes to WAIT_SOF when enable_i is high.
  - WAIT_SOF: waits for sof. On sof goes to ACTIVE with L=0, W=0, error_count=0 and the first-error capture armed.
  - ACTIVE: each data_valid_i compares data_i with E(L,W).
    - W increments per valid word; at W=WORDS_PER_LINE-1, W wraps to 0 and L increments.
    - The word at L=LINES_PER_FRAME-1, W=WORDS_PER_LINE-1 ends the frame and goes to DONE.
  - DONE: one cycle only. Pulses frame_done_o, loads frame_ok_o = (error_count==0 including the final word), then goes to WAIT_SOF.
- Mismatch handling: error_count increments, saturating. The first mismatch of a frame latches line, word and data into first_err_* and disarms the capture.
- Early SOF, i.e. sof in ACTIVE before the last word:
  - The frame is short. error_count increments by 1, frame_done_o pulses, frame_ok_o=0.
  - If the capture is still armed, first_err_* latch the current L, W and data_i.
  - The checker re-enters ACTIVE immediately for the new frame with counters reset.
- sof and data_valid_i in the same cycle: that word is word 0 of line 0 of the new frame and is checked.
- data_valid_i in WAIT_SOF, DONE or IDLE: the word is ignored and overrun_o is set. Cleared only by clear_i or reset.
- clear_i: zeros error_count, first_err_*, overrun_o and frame_ok_o, and forces WAIT_SOF (IDLE if enable_i is low). clear_i has priority over all other events in that cycle.
- enable_i falling mid-frame: state goes to IDLE next cycle, no frame_done_o, status outputs hold.

## Timing
- Reset values:
  - state IDLE.
  - busy_o, frame_done_o, frame_ok_o, overrun_o = 0.
  - error_count_o, line_count_o, word_count_o, first_err_* = 0.
  - fs_q = 1, so a framesync_i held high through reset is not an SOF.
- All outputs are registered.
- Counters and error_count_o reflect a word one cycle after its data_valid_i.
- frame_done_o asserts the cycle after the last word is accepted (DONE state). frame_ok_o is valid in that same cycle and held until the next frame end.
- An SOF in DONE is not lost: it is captured and taken on entry to WAIT_SOF the next cycle. The word sampled in DONE counts as overrun.
- Back-to-back valid words every cycle are supported with no stall; there is no backpressure output.

## Test plan
- Clean frame (WORDS_PER_LINE=16, LINES_PER_FRAME=4): SOF, then 64 correct words -> frame_done_o one cycle after word 63, frame_ok_o=1, error_count_o=0.
- Corrupt word L=2 W=5: send 16'h0000 instead of E=16'h0205 -> error_count_o=1, first_err_line_o=2, first_err_word_o=5, first_err_data_o=16'h0000, frame_ok_o=0.
- Odd-line inversion: line 1, word 3 must be 16'hFEFC; sending 16'h0103 -> one error counted.
- Early SOF after 20 words -> frame_done_o pulse, frame_ok_o=0, error_count_o=1, first_err_line_o=1, first_err_word_o=4; a new frame starts with SOF-cycle word checked as L=0, W=0.
- Valid words before any SOF -> overrun_o=1; clear_i -> overrun_o=0, error_count_o=0.
- All-zero data for 65536+ words (LINES_PER_FRAME=1024, WORDS_PER_LINE=4096) -> error_count_o saturates at 16'hFFFF; async reset mid-frame returns all outputs to reset values immediately.
